// File: rtl/ext_gpio_defs_pkg.sv
// Shared GPIO definitions used by the input filter and the GPIO controller.
package ext_gpio_defs;

  localparam int GPIO_WIDTH          = 32;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_CNT_WIDTH       = 10;
  localparam int DEF_SYNC_STAGES     = 2;

  // True when a counter of cnt_width bits can reach debounce_cycles-1.
  function automatic bit cnt_width_ok(input int cnt_width, input int debounce_cycles);
    return (64'(1) << cnt_width) >= 64'(debounce_cycles);
  endfunction

endpackage

// File: rtl/ext_gpio_debounce_bit.sv
// One GPIO input bit: synchroniser, debounce counter, stable level and edge pulses.
module ext_gpio_debounce_bit #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter int   CNT_WIDTH       = 10,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic pad,
  input  logic filter_en,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic                   level_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d   = '0;
    level_d = level;
    if (!filter_en) begin
      level_d = s;
    end else if (s != level) begin
      // Counter saturates at the terminal value by accepting the new level and clearing.
      if (cnt_q == CNT_LAST) begin
        level_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(negedge sys_clk) begin
    if (sys_rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= RESET_BIT;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      cnt_q  <= cnt_d;
      level  <= level_d;
      rise   <= ~level & level_d;
      fall   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/ext_gpio_in_filter.sv
// Synchronises and debounces the GPIO pad inputs feeding the controller's gpio_in.
module ext_gpio_in_filter
  import ext_gpio_defs::*;
#(
  parameter int               WIDTH           = GPIO_WIDTH,
  parameter int               SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int               CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] pad_in,
  input  logic             filter_en,
  output logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || !cnt_width_ok(CNT_WIDTH, DEBOUNCE_CYCLES)) begin : g_bad_params
    $error("ext_gpio_in_filter: illegal parameter combination");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ext_gpio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH),
      .RESET_BIT       (RESET_VAL[i])
    ) u_bit (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .pad       (pad_in[i]),
      .filter_en (filter_en),
      .level     (gpio_in[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

endmodule

// File: tb/tb_ext_gpio_in_filter.sv
// Directed bench for ext_gpio_in_filter with a short debounce window.
module tb_ext_gpio_in_filter;

  logic        sys_clk = 1'b1;
  logic        sys_rst;
  logic [31:0] pad_in;
  logic        filter_en;
  logic [31:0] gpio_in;
  logic [31:0] rise;
  logic [31:0] fall;

  int n_checks = 0;
  int n_errors = 0;
  int rise_cnt;

  always #5 sys_clk = ~sys_clk;

  ext_gpio_in_filter #(
    .WIDTH           (32),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_WIDTH       (3),
    .RESET_VAL       (32'd0)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .pad_in    (pad_in),
    .filter_en (filter_en),
    .gpio_in   (gpio_in),
    .rise      (rise),
    .fall      (fall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one active (negative) edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  initial begin
    sys_rst   = 1'b1;
    pad_in    = '0;
    filter_en = 1'b1;
    tick(3);
    chk("reset_gpio", gpio_in, 32'h0);
    chk("reset_rise", rise, 32'h0);
    chk("reset_fall", fall, 32'h0);
    sys_rst = 1'b0;
    tick(2);

    // 1: single bit accepted on 6th edge
    pad_in = 32'h0000_0001;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("t1_hold_e%0d", i), gpio_in, 32'h0);
    end
    tick();
    chk("t1_gpio_e6", gpio_in, 32'h1);
    chk("t1_rise_e6", rise, 32'h1);
    chk("t1_fall_e6", fall, 32'h0);
    tick();
    chk("t1_rise_e7", rise, 32'h0);
    chk("t1_gpio_e7", gpio_in, 32'h1);
    pad_in = 32'h0;
    tick(5);
    chk("t1_fall_early", fall, 32'h0);
    tick();
    chk("t1_gpio_back", gpio_in, 32'h0);
    chk("t1_fall_e6", fall, 32'h1);
    tick(2);

    // 2: 3-cycle glitch on bit 3 is rejected
    rise_cnt = 0;
    pad_in = 32'h0000_0008;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) pad_in = 32'h0;
      tick();
      if (rise[3]) rise_cnt++;
      if (gpio_in[3]) rise_cnt += 100;
    end
    chk("t2_glitch", 32'(rise_cnt), 32'h0);
    chk("t2_gpio", gpio_in, 32'h0);

    // 3: bit 5 toggling every 2 cycles, then held high
    rise_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      pad_in[5] = (((c / 2) % 2) == 0);
      tick();
      if (rise[5]) rise_cnt++;
    end
    pad_in[5] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (rise[5]) rise_cnt++;
      chk($sformatf("t3_hold_e%0d", i), {31'h0, gpio_in[5]}, 32'h0);
    end
    tick();
    if (rise[5]) rise_cnt++;
    chk("t3_gpio_e6", gpio_in, 32'h0000_0020);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rise[5]) rise_cnt++;
    end
    chk("t3_rise_total", 32'(rise_cnt), 32'h1);
    pad_in = 32'h0;
    tick(8);
    chk("t3_gpio_clear", gpio_in, 32'h0);

    // 4: bypass mode
    filter_en = 1'b0;
    pad_in = 32'hA5A5_A5A5;
    tick(2);
    chk("t4_gpio_e2", gpio_in, 32'h0);
    tick();
    chk("t4_gpio_e3", gpio_in, 32'hA5A5_A5A5);
    chk("t4_rise_e3", rise, 32'hA5A5_A5A5);
    tick();
    chk("t4_rise_e4", rise, 32'h0);
    pad_in = 32'h0;
    tick(3);
    chk("t4_fall_e3", fall, 32'hA5A5_A5A5);
    chk("t4_gpio_clear", gpio_in, 32'h0);
    filter_en = 1'b1;
    tick(2);

    // 5: reset discards a mid-count debounce
    pad_in = 32'h0000_0080;
    tick(4);
    chk("t5_pre_reset", gpio_in, 32'h0);
    sys_rst = 1'b1;
    tick();
    chk("t5_reset_gpio", gpio_in, 32'h0);
    chk("t5_reset_rise", rise, 32'h0);
    sys_rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("t5_hold_e%0d", i), gpio_in, 32'h0);
    end
    tick();
    chk("t5_gpio_e6", gpio_in, 32'h0000_0080);
    chk("t5_rise_e6", rise, 32'h0000_0080);
    pad_in = 32'h0;
    tick(8);
    chk("t5_gpio_clear", gpio_in, 32'h0);

    // 6: all bits together
    pad_in = 32'hFFFF_FFFF;
    tick(5);
    chk("t6_gpio_e5", gpio_in, 32'h0);
    chk("t6_rise_e5", rise, 32'h0);
    tick();
    chk("t6_gpio_e6", gpio_in, 32'hFFFF_FFFF);
    chk("t6_rise_e6", rise, 32'hFFFF_FFFF);
    chk("t6_fall_e6", fall, 32'h0);
    tick();
    chk("t6_rise_e7", rise, 32'h0);
    chk("t6_gpio_e7", gpio_in, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
